aes192_key_unroll: RTL

// - Inverse AES-192 key schedule for the decryption datapath.
// - Loads the final 192-bit expansion window (words w48..w53, after 8 forward steps).
// - Walks the schedule backwards, one 192-bit window per handshake, ending at the cipher key (w0..w5).
// - Consumer is the decrypt round-key buffer; it receives windows in order 8,7,...,0.

---
 rtl/aes192_key_unroll.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/aes192_key_unroll.sv
// Inverse AES-192 key schedule: loads expansion window 8 (w48..w53) and steps back to the cipher key.
// Define AES192_UNROLL_PIPE_EN to register the SubWord result and split each backward step over two cycles.
module aes192_key_unroll #(
  parameter int NSTEPS = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [191:0] i_key_last,
  output logic         o_busy,
  output logic         o_win_valid,
  input  logic         i_win_ready,
  output logic [191:0] o_win_data,
  output logic [3:0]   o_win_idx,
  output logic         o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EMIT  = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
`ifdef AES192_UNROLL_PIPE_EN
  localparam logic [1:0] S_STEP2 = 2'd3;
`endif

  logic [1:0]   r_state;
  logic [191:0] r_win;
  logic [3:0]   r_idx;
  logic         r_busy;
  logic         r_valid;
  logic         r_done;
  logic [31:0]  r_sub;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_w4, w_w5;
  logic [159:0] w_low;
  logic [31:0]  w_sub;
  logic [31:0]  w_subSel;
  logic [31:0]  w_newW0;
  logic [7:0]   w_rc;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  assign w_w0 = r_win[191:160];
  assign w_w1 = r_win[159:128];
  assign w_w2 = r_win[127:96];
  assign w_w3 = r_win[95:64];
  assign w_w4 = r_win[63:32];
  assign w_w5 = r_win[31:0];

  // Words 1..5 of the previous window are pairwise XORs; only word 0 needs SubWord and rcon
  assign w_low   = {w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2, w_w4 ^ w_w3, w_w5 ^ w_w4};
  assign w_sub   = subRotWord(w_w5 ^ w_w4);
  assign w_rc    = 8'h01 << (r_idx - 4'd1);
`ifdef AES192_UNROLL_PIPE_EN
  assign w_subSel = r_sub;
`else
  assign w_subSel = w_sub;
`endif
  assign w_newW0 = w_w0 ^ w_subSel ^ {w_rc, 24'h000000};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_sub   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_win   <= i_key_last;
            r_idx   <= 4'(NSTEPS);
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (i_win_ready) begin
            r_valid <= 1'b0;
            if (r_idx == 4'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_STEP;
            end
          end
        end
`ifdef AES192_UNROLL_PIPE_EN
        S_STEP: begin
          // word 0 still holds W0 until STEP2 combines it with the registered SubWord
          r_win[159:0] <= w_low;
          r_sub        <= w_sub;
          r_state      <= S_STEP2;
        end
        S_STEP2: begin
          r_win[191:160] <= w_newW0;
          r_idx          <= r_idx - 4'd1;
          r_valid        <= 1'b1;
          r_state        <= S_EMIT;
        end
`else
        S_STEP: begin
          r_win   <= {w_newW0, w_low};
          r_idx   <= r_idx - 4'd1;
          r_valid <= 1'b1;
          r_state <= S_EMIT;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_win_valid = r_valid;
  assign o_win_data  = r_win;
  assign o_win_idx   = r_idx;
  assign o_done      = r_done;

endmodule
